// File: rtl/router_pkt_register_if.sv
// Router packet-register bus: the byte stream from the source, the
// destination FIFO status, the FSM state strobes, and the flags and
// data returned by the register block.
interface router_pkt_register_if;
    logic [7:0] data_in;
    logic       pkt_valid;
    logic       fifo_full;
    logic       detect_addr;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;
    logic [7:0] dout;

    // Source and FSM side: drives the stream and strobes, observes the flags.
    modport master (
        output data_in, pkt_valid, fifo_full,
        output detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        input  parity_done, low_pkt_valid, err, dout
    );

    // Register block side.
    modport slave (
        input  data_in, pkt_valid, fifo_full,
        input  detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        output parity_done, low_pkt_valid, err, dout
    );
endinterface

// File: rtl/router_pkt_register.sv
// Router packet register: latches the header, forwards header and payload
// bytes to the destination FIFO, keeps the byte that arrives while the FIFO
// is full, and computes and checks packet parity.
// Optional feature: define ROUTER_REG_LEN_CHECK_EN to also count payload
// bytes and flag an error when the count differs from the header length.
module router_pkt_register (
    input  logic                  clk,
    input  logic                  reset,
    router_pkt_register_if.slave  bus
);

    logic [7:0] hdr_byte;
    logic [7:0] hold_byte;
    logic [7:0] int_parity;
    logic [7:0] pkt_parity;
    logic [7:0] dout_q;
    logic       parity_done_q;
    logic       low_pkt_valid_q;
    logic       err_q;
    logic       err_next;

    // A payload byte contributes to parity (and to the length count) only
    // in the cycle it is first presented in the load state.
    logic       payload_take;
    assign payload_take = bus.ld_state && bus.pkt_valid && !bus.full_state;

    // Capture the header, except for address 3, which names no destination.
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // see pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hdr_byte <= 8'h00;
        else if (bus.detect_addr && bus.pkt_valid && bus.data_in[1:0] != 2'b11)
            hdr_byte <= bus.data_in;
    end

    // Output byte selection: header first, then live payload, then the held byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dout_q <= 8'h00;
        else if (bus.lfd_state)
            dout_q <= hdr_byte;
        else if (bus.ld_state && !bus.fifo_full)
            dout_q <= bus.data_in;
        else if (bus.laf_state)
            dout_q <= hold_byte;
    end

    // Keep the byte presented while the FIFO is full so it is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hold_byte <= 8'h00;
        else if (bus.ld_state && bus.fifo_full)
            hold_byte <= bus.data_in;
    end

    // Running XOR of header and payload bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            int_parity <= 8'h00;
        else if (bus.detect_addr)
            int_parity <= 8'h00;
        else if (bus.lfd_state)
            int_parity <= int_parity ^ hdr_byte;
        else if (payload_take)
            int_parity <= int_parity ^ bus.data_in;
    end

    // Parity byte sent by the source, which arrives with pkt_valid low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pkt_parity <= 8'h00;
        else if (bus.detect_addr)
            pkt_parity <= 8'h00;
        else if (bus.ld_state && !bus.pkt_valid)
            pkt_parity <= bus.data_in;
    end

    // Flag that the packet ended while loading; cleared by the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            low_pkt_valid_q <= 1'b0;
        else if (bus.rst_int_reg)
            low_pkt_valid_q <= 1'b0;
        else if (bus.ld_state && !bus.pkt_valid)
            low_pkt_valid_q <= 1'b1;
    end

    // Parity captured either directly or after the FIFO-full detour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            parity_done_q <= 1'b0;
        else if (bus.detect_addr)
            parity_done_q <= 1'b0;
        else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
                 (bus.laf_state && low_pkt_valid_q && !parity_done_q))
            parity_done_q <= 1'b1;
    end

`ifdef ROUTER_REG_LEN_CHECK_EN
    logic [5:0] pay_cnt;

    // Saturating count of payload bytes in the current packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pay_cnt <= 6'd0;
        else if (bus.detect_addr)
            pay_cnt <= 6'd0;
        else if (payload_take && pay_cnt != 6'd63)
            pay_cnt <= pay_cnt + 6'd1;
    end

    // Error when parity or payload length disagrees with the packet.
    // NOTE: combinational outputs are assigned on every path so no latch is inferred.
    always_comb begin
        err_next = (int_parity != pkt_parity) || (pay_cnt != hdr_byte[7:2]);
    end
`else
    // Error when the computed parity disagrees with the transmitted parity.
    // NOTE: combinational outputs are assigned on every path so no latch is inferred.
    always_comb begin
        err_next = (int_parity != pkt_parity);
    end
`endif

    // Register the check while parity_done is high; hold until the next header.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else if (bus.detect_addr)
            err_q <= 1'b0;
        else if (parity_done_q)
            err_q <= err_next;
    end

    assign bus.dout          = dout_q;
    assign bus.parity_done   = parity_done_q;
    assign bus.low_pkt_valid = low_pkt_valid_q;
    assign bus.err           = err_q;

endmodule

// File: tb/tb_router_pkt_register.sv
// Self-checking bench for router_pkt_register. The bench plays the role of
// the router FSM, walking each packet through detect/lfd/ld/full/laf steps.
// Expected values come from a packet-level model: the byte stream that must
// appear on dout, and the parity (and, with ROUTER_REG_LEN_CHECK_EN, length)
// verdict computed from the packet contents.
module tb_router_pkt_register;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    router_pkt_register_if bus ();

    router_pkt_register dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] pl [64];
    int         pl_n;
    logic [7:0] last_hdr;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.data_in     = 8'h00;
        bus.pkt_valid   = 1'b0;
        bus.fifo_full   = 1'b0;
        bus.detect_addr = 1'b0;
        bus.lfd_state   = 1'b0;
        bus.ld_state    = 1'b0;
        bus.laf_state   = 1'b0;
        bus.full_state  = 1'b0;
        bus.rst_int_reg = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One byte through the load state, optionally via the FIFO-full detour.
    task automatic send_byte(input logic [7:0] b, input logic pv, input logic full);
        idle();
        bus.ld_state  = 1'b1;
        bus.pkt_valid = pv;
        bus.data_in   = b;
        bus.fifo_full = full;
        tick();
        if (!full) begin
            check("ld_dout", bus.dout, b);
        end else begin
            idle();
            bus.full_state = 1'b1;
            bus.fifo_full  = 1'b1;
            bus.pkt_valid  = pv;
            bus.data_in    = ~b;
            repeat ($urandom_range(1, 2)) tick();
            idle();
            bus.laf_state = 1'b1;
            bus.pkt_valid = pv;
            bus.data_in   = ~b;
            tick();
            check("laf_dout", bus.dout, b);
        end
    endtask

    // Header detection for address 3: nothing latched, flags cleared.
    task automatic addr3_probe(input logic [7:0] hdr);
        idle();
        bus.detect_addr = 1'b1;
        bus.pkt_valid   = 1'b1;
        bus.data_in     = hdr;
        tick();
        check("a3_pdone", bus.parity_done, 8'h00);
        check("a3_err", bus.err, 8'h00);
        idle();
        bus.lfd_state = 1'b1;
        bus.pkt_valid = 1'b1;
        bus.data_in   = 8'($urandom);
        tick();
        check("a3_hdr_kept", bus.dout, last_hdr);
        idle();
    endtask

    // Full packet: header, pl[0..pl_n-1], parity byte. full_mask bit i stalls byte i
    // (bit pl_n stalls the parity byte).
    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] parity, input logic [63:0] full_mask);
        logic [7:0] model_par;
        logic       exp_err;
        int         cnt;
        model_par = hdr;
        for (int i = 0; i < pl_n; i++) model_par ^= pl[i];
        exp_err = (model_par != parity);
`ifdef ROUTER_REG_LEN_CHECK_EN
        cnt = (pl_n > 63) ? 63 : pl_n;
        if (cnt != int'(hdr[7:2])) exp_err = 1'b1;
`else
        cnt = pl_n;
`endif
        idle();
        bus.detect_addr = 1'b1;
        bus.pkt_valid   = 1'b1;
        bus.data_in     = hdr;
        tick();
        check("det_pdone", bus.parity_done, 8'h00);
        check("det_err", bus.err, 8'h00);
        last_hdr = hdr;

        idle();
        bus.lfd_state = 1'b1;
        bus.pkt_valid = 1'b1;
        bus.data_in   = 8'($urandom);
        tick();
        check("hdr_dout", bus.dout, hdr);

        for (int i = 0; i < pl_n; i++) send_byte(pl[i], 1'b1, full_mask[i]);
        send_byte(parity, 1'b0, full_mask[pl_n]);
        check("pdone", bus.parity_done, 8'h01);
        check("lowpv_set", bus.low_pkt_valid, 8'h01);
        check("err_pre", bus.err, 8'h00);

        idle();
        tick();
        check("err", bus.err, {7'd0, exp_err});
        check("lowpv_held", bus.low_pkt_valid, 8'h01);

        idle();
        bus.rst_int_reg = 1'b1;
        tick();
        check("lowpv_clr", bus.low_pkt_valid, 8'h00);
        check("err_hold", bus.err, {7'd0, exp_err});
        idle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"}, bus.dout, 8'h00);
        check({tag, "_pdone"}, bus.parity_done, 8'h00);
        check({tag, "_lowpv"}, bus.low_pkt_valid, 8'h00);
        check({tag, "_err"}, bus.err, 8'h00);
    endtask

    initial begin
        logic [63:0] mask;
        logic [7:0]  hdr;
        logic [7:0]  par;
        int          len;

        idle();
        reset = 1'b1;
        last_hdr = 8'h00;
        tick();
        tick();
        check_all_zero("rst");
        reset = 1'b0;
        tick();

        // Good packet 0D / 11 22 33 / 0D.
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl_n = 3;
        send_pkt(8'h0D, 8'h0D, 64'd0);
        // Same packet with a corrupted parity byte.
        send_pkt(8'h0D, 8'h0E, 64'd0);
        // FIFO full while 22 is presented.
        send_pkt(8'h0D, 8'h0D, 64'b010);
        // FIFO full on the parity byte itself.
        send_pkt(8'h0D, 8'h0D, 64'b1000);
        // Leave err set, then an address-3 header must clear it without latching.
        send_pkt(8'h0D, 8'h0E, 64'd0);
        addr3_probe(8'h0F);
        // Short packet: parity correct, length field says 3 but only 2 bytes.
        pl[0] = 8'hA5; pl[1] = 8'h5A; pl_n = 2;
        send_pkt(8'h0D, 8'hF2, 64'd0);

        // Asynchronous reset after the second payload byte.
        idle();
        bus.detect_addr = 1'b1; bus.pkt_valid = 1'b1; bus.data_in = 8'h0D;
        tick();
        idle();
        bus.lfd_state = 1'b1; bus.pkt_valid = 1'b1;
        tick();
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 check_all_zero("async_rst");
        tick();
        reset = 1'b0;
        last_hdr = 8'h00;
        tick();
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl_n = 3;
        send_pkt(8'h0D, 8'h0D, 64'd0);

        // Randomized packets.
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 6) == 0) addr3_probe({6'($urandom), 2'b11});
            pl_n = $urandom_range(1, 10);
            len  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : pl_n;
            hdr  = {6'(len), 2'($urandom_range(0, 2))};
            par  = hdr;
            mask = 64'd0;
            for (int i = 0; i < pl_n; i++) begin
                pl[i] = 8'($urandom);
                par ^= pl[i];
            end
            for (int i = 0; i <= pl_n; i++) mask[i] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) par ^= 8'($urandom_range(1, 255));
            send_pkt(hdr, par, mask);
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
